// File: rtl/ysyx_25050141_mem_arbiter.sv
// Two-requester (IF/LS) memory arbiter: round-robin grant, one outstanding
// transaction, response timeout that returns an error instead of stalling.
module ysyx_25050141_mem_arbiter #(
  parameter int unsigned AddrW   = 32,
  parameter int unsigned DataW   = 32,
  parameter int unsigned Timeout = 255
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               if_req_valid_i,
  output logic               if_req_ready_o,
  input  logic [AddrW-1:0]   if_req_addr_i,
  output logic               if_resp_valid_o,
  input  logic               if_resp_ready_i,
  output logic [DataW-1:0]   if_resp_rdata_o,
  output logic               if_resp_err_o,
  input  logic               ls_req_valid_i,
  output logic               ls_req_ready_o,
  input  logic [AddrW-1:0]   ls_req_addr_i,
  input  logic               ls_req_wen_i,
  input  logic [DataW-1:0]   ls_req_wdata_i,
  input  logic [DataW/8-1:0] ls_req_wmask_i,
  output logic               ls_resp_valid_o,
  input  logic               ls_resp_ready_i,
  output logic [DataW-1:0]   ls_resp_rdata_o,
  output logic               ls_resp_err_o,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [AddrW-1:0]   mem_req_addr_o,
  output logic               mem_req_wen_o,
  output logic [DataW-1:0]   mem_req_wdata_o,
  output logic [DataW/8-1:0] mem_req_wmask_o,
  input  logic               mem_resp_valid_i,
  output logic               mem_resp_ready_o,
  input  logic [DataW-1:0]   mem_resp_rdata_i
);

  localparam logic [7:0] TimeoutCnt = 8'(Timeout);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;  // 1 = LS, 0 = IF
  logic                 last_q, last_d;    // 1 = LS, 0 = IF
  logic [AddrW-1:0]     addr_q, addr_d;
  logic                 wen_q, wen_d;
  logic [DataW-1:0]     wdata_q, wdata_d;
  logic [DataW/8-1:0]   wmask_q, wmask_d;
  logic [DataW-1:0]     rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 grant_ls;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if_req_ready_o  = 1'b0;
    ls_req_ready_o  = 1'b0;
    if_resp_valid_o = 1'b0;
    ls_resp_valid_o = 1'b0;
    mem_req_valid_o = 1'b0;
    // On a tie LS wins unless it was the last one served.
    grant_ls = ls_req_valid_i && (!if_req_valid_i || !last_q);

    unique case (state_q)
      StIdle: begin
        if (if_req_valid_i || ls_req_valid_i) begin
          ls_req_ready_o = grant_ls;
          if_req_ready_o = !grant_ls;
          owner_d        = grant_ls;
          state_d        = StReq;
          if (grant_ls) begin
            addr_d  = ls_req_addr_i;
            wen_d   = ls_req_wen_i;
            wdata_d = ls_req_wdata_i;
            wmask_d = ls_req_wmask_i;
          end else begin
            addr_d  = if_req_addr_i;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      StReq: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        // A response in the final waiting cycle still wins over the timeout.
        if (mem_resp_valid_i) begin
          rdata_d = mem_resp_rdata_i;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == TimeoutCnt) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        if_resp_valid_o = !owner_q;
        ls_resp_valid_o = owner_q;
        if (owner_q ? ls_resp_ready_i : if_resp_ready_i) begin
          last_d  = owner_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Responses arriving outside WAIT are accepted and dropped.
  assign mem_resp_ready_o = 1'b1;
  assign mem_req_addr_o   = addr_q;
  assign mem_req_wen_o    = wen_q;
  assign mem_req_wdata_o  = wdata_q;
  assign mem_req_wmask_o  = wmask_q;
  assign if_resp_rdata_o  = wen_q ? '0 : rdata_q;
  assign ls_resp_rdata_o  = wen_q ? '0 : rdata_q;
  assign if_resp_err_o    = err_q;
  assign ls_resp_err_o    = err_q;

endmodule
